gray_mem_arbiter: RTL

//  Shares the single gray-image read port (gray_addr/gray_req/gray_ready/gray_data)

---
 rtl/gray_mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter: lets two pixel engines share the single gray-image read port.
// Engine 0 is the LBP engine and engine 1 is the second filter engine.
//
// Arbitration:
//  - One read is granted per cycle.
//  - Round-robin with burst hold: the current owner keeps winning contention
//    until it has taken BURST_MAX grants in a row. A 3x3 window fetch therefore
//    stays contiguous.
//  - The burst limit only matters when both engines are requesting. A lone
//    requester is granted every cycle.
//
// Read return:
//  - Each returned pixel is routed back to its requester.
//  - The latency is a fixed three cycles, and the reads are fully pipelined.
//
// Optional feature (macro GRAY_ARB_FIXED_PRIO_EN):
//  - When defined, requester 0 always wins contention.
//  - Requester 1 is then granted only while req0 is low.
//
// Handshake: reqN/addrN are a level request held by the engine until it is
// accepted. gntN is a combinational accept, and the request is consumed on the
// clock edge where gntN=1. rvalidN is a one-cycle pulse. It arrives three cycles
// after the matching grant, in strict grant order, with no back-pressure.
module gray_mem_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int BURST_MAX = 9,
  parameter int CW        = $clog2(BURST_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic          gray_ready,
  input  logic [DW-1:0] gray_data,
  output logic          dbg_owner,
  output logic [CW-1:0] dbg_burst_cnt
);

  // Arbitration state: the last requester granted and its run length.
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Memory command registers.
  logic          gray_req_q, gray_req_d;
  logic [AW-1:0] gray_addr_q, gray_addr_d;

  // Two-stage tag pipe {valid,id}. It follows each read from grant to data return.
  logic          tag1_v_q, tag1_v_d, tag1_id_q, tag1_id_d;
  logic          tag2_v_q, tag2_v_d, tag2_id_q, tag2_id_d;

  // Return registers.
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grant selection. Nothing is granted in reset or while the memory is busy.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b1 & 1'b0;
    if (!reset && gray_ready) begin
      if (req0 && req1) begin
`ifdef GRAY_ARB_FIXED_PRIO_EN
        gnt0 = 1'b1;
`else
        // Owner wins, unless its burst is used up. Then the waiting side wins.
        if (owner_q ^ (cnt_q == CW'(BURST_MAX))) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`endif
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Owner and burst count update.
  // A repeat grant extends the run, saturating at the limit.
  // A switch of requester starts a new run at 1.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (gnt0 || gnt1) begin
      if (gnt1 == owner_q) begin
        if (cnt_q != CW'(BURST_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        owner_d = gnt1;
        cnt_d   = CW'(1);
      end
    end
  end

  // Read pipeline:
  //  - The memory command is issued on the cycle after the grant.
  //  - The data is captured two cycles after the grant.
  //  - The data is then presented to its requester.
  always_comb begin
    gray_req_d  = gnt0 | gnt1;
    gray_addr_d = gray_addr_q;
    if (gnt1) begin
      gray_addr_d = addr1;
    end else if (gnt0) begin
      gray_addr_d = addr0;
    end
    tag1_v_d  = gnt0 | gnt1;
    tag1_id_d = gnt1;
    tag2_v_d  = tag1_v_q;
    tag2_id_d = tag1_id_q;
    rvalid0_d = tag2_v_q & ~tag2_id_q;
    rvalid1_d = tag2_v_q & tag2_id_q;
    rdata0_d  = rvalid0_d ? gray_data : rdata0_q;
    rdata1_d  = rvalid1_d ? gray_data : rdata1_q;
  end

  // State registers. Reset flushes in-flight reads, so their data never returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      tag1_v_q    <= 1'b0;
      tag1_id_q   <= 1'b0;
      tag2_v_q    <= 1'b0;
      tag2_id_q   <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      tag1_v_q    <= tag1_v_d;
      tag1_id_q   <= tag1_id_d;
      tag2_v_q    <= tag2_v_d;
      tag2_id_q   <= tag2_id_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign gray_req      = gray_req_q;
  assign gray_addr     = gray_addr_q;
  assign rvalid0       = rvalid0_q;
  assign rvalid1       = rvalid1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign dbg_owner     = owner_q;
  assign dbg_burst_cnt = cnt_q;

endmodule
